interval_tick_8b: RTL and testbench
===================================

# interval_tick_8b

Programmable interval timer that sits directly downstream of the free-running 8-bit counter and consumes its `count` output. A period is loaded through a valid/ready handshake. The block then emits a one-cycle `tick` every `period` cycles, measured as 8-bit modular distance on the incoming count. It also keeps a running tally of ticks issued. It lets the rest of the lab datapath schedule periodic events without owning a second counter.

## Interface
Parameters:
- none (width fixed at 8 bits)

Ports:
- `clk` in 1 — sole clock; all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `count` in 8 — output of the upstream free-running counter; increments by exactly one per cycle, wraps 255→0
- `cfg_val` in 1 — configuration request valid
- `cfg_period` in 8 — requested period in cycles, 1..255
- `cfg_rdy` out 1 — block can accept configuration
- `stop` in 1 — return to idle
- `busy` out 1 — timer running
- `tick` out 1 — one-cycle pulse per elapsed period (registered)
- `ticks` out 8 — number of ticks issued since reset or last configuration; wraps 255→0

## Operation
- State machine, two states:
  - IDLE: `cfg_rdy`=1, `busy`=0.
  - RUN: `cfg_rdy`=0, `busy`=1.
- Internal registers: `base` (8b), `period` (8b).
- IDLE, `cfg_val`=1, `cfg_period`≠0:
  - handshake fires
  - `period`←`cfg_period`, `base`←`count`, `ticks`←0
  - next state RUN
- IDLE, `cfg_val`=1, `cfg_period`=0:
  - handshake fires, but the request is discarded
  - state stays IDLE; `ticks` and `period` unchanged
- RUN, each cycle, `elapsed` = (`count` − `base`) mod 256:
  - 8-bit subtraction, borrow discarded
  - wrap of `count` across 255→0 is handled by the modular subtract
- RUN, `elapsed` == `period`:
  - `tick`←1 on the next edge, `ticks`←`ticks`+1 (mod 256)
  - `base`←`count` (re-arm)
  - state stays RUN
- RUN, `cfg_val` ignored; no handshake occurs.
- `stop`=1 in RUN:
  - next state IDLE, `tick`←0
  - stop overrides a simultaneous match: no tick, `ticks` not incremented
- `stop` in IDLE: no effect. If asserted together with `cfg_val`, the configuration is accepted and stop is ignored.
- `rst`=1 has highest priority, in any state and mid-period.

## Timing
- Reset values: state IDLE, `cfg_rdy`=1, `busy`=0, `tick`=0, `ticks`=0, `base`=0, `period`=0.
- Configuration accepted at edge E0 with `count`=c0:
  - `busy`=1 from E0.
  - First match in the cycle where `count`=c0+p (mod 256).
  - `tick` high for exactly the cycle following that match, i.e. p+1 cycles after E0.
  - Subsequent ticks spaced exactly p cycles apart.
- `period`=1: `tick` high every cycle from cycle 2 after acceptance; `ticks` increments every cycle.
- `ticks` updates on the same edge that raises `tick`.
- `cfg_rdy` and `busy` are pure decodes of the state register: no combinational path from any input.
- `stop` takes effect on the next edge; `cfg_rdy` returns to 1 the cycle after.

## Configuration
- `INTERVAL_TICK_ONESHOT_EN`:
  - defined: after issuing its first tick, the block returns to IDLE on the same edge that raises `tick` (`busy`=0, `cfg_rdy`=1 during the tick cycle); `ticks` ends at 1.
  - undefined: periodic mode as described above; the block re-arms and runs until `stop` or `rst`.

## Test plan
- Reset check: `rst`=1 for 2 cycles → `tick`=0, `ticks`=0, `busy`=0, `cfg_rdy`=1.
- Basic period: accept `cfg_period`=4 at `count`=10 → ticks in cycles where `count`=15, 19, 23; `ticks` reads 1, 2, 3.
- Wrap-around: accept `cfg_period`=8 at `count`=252 → first tick in cycle where `count`=5; the next at `count`=13.
- Zero period and busy reject:
  - `cfg_period`=0 in IDLE → stays IDLE, no tick.
  - `cfg_val` with `cfg_period`=3 while RUN → ignored; the original period persists.
- Stop collision: period 5, assert `stop` in the match cycle → no tick, `ticks` unchanged, `busy`=0 next cycle.
- Reset mid-run: `rst` asserted 2 cycles before an expected tick → no tick, all outputs at reset values next cycle.
- With `INTERVAL_TICK_ONESHOT_EN`: period 3 → exactly one tick, then `busy`=0 and `ticks`=1 held indefinitely.

Source files
------------

// File: rtl/interval_tick_8b.sv
// interval_tick_8b
//
// Programmable interval timer that consumes the count of an upstream
// free-running 8-bit counter. A period is loaded through a valid/ready
// handshake. While running, the block emits a one-cycle registered tick each
// time the modular distance (count - base) reaches the period. It then re-arms
// from the current count. It also keeps a wrapping tally of ticks issued.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   count [7:0] in   upstream free-running count (+1 per cycle, wraps)
//   cfg_val     in   configuration request valid
//   cfg_period  in   requested period 1..255 (0 is accepted and discarded)
//   cfg_rdy     out  block can accept configuration (IDLE)
//   stop        in   return to idle (RUN only)
//   busy        out  timer running (RUN)
//   tick        out  one-cycle pulse per elapsed period (registered)
//   ticks [7:0] out  ticks since reset or last configuration, wraps
//
// Build option:
//   INTERVAL_TICK_ONESHOT_EN  when defined, the block returns to IDLE on the
//                             edge that raises the first tick.
//
// state | meaning
// IDLE  | waiting for configuration, cfg_rdy=1
// RUN   | measuring elapsed count against period, busy=1

module interval_tick_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       cfg_val,
  input  logic [7:0] cfg_period,
  output logic       cfg_rdy,
  input  logic       stop,
  output logic       busy,
  output logic       tick,
  output logic [7:0] ticks
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [7:0] period_q, period_d;
  logic [7:0] ticks_q, ticks_d;
  logic       tick_q, tick_d;

  logic [7:0] elapsed;
  logic       match;

  // Modular subtract: the borrow is dropped, so a count wrap needs no special case.
  assign elapsed = count - base_q;
  assign match   = (elapsed == period_q);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    period_d = period_q;
    ticks_d  = ticks_q;
    tick_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A zero period completes the handshake but changes nothing.
        if (cfg_val && (cfg_period != 8'd0)) begin
          state_d  = S_RUN;
          period_d = cfg_period;
          base_d   = count;
          ticks_d  = 8'd0;
        end
      end
      S_RUN: begin
        // stop wins over a coincident match: no tick and no tally update.
        if (stop) begin
          state_d = S_IDLE;
        end else if (match) begin
          tick_d  = 1'b1;
          ticks_d = ticks_q + 8'd1;
          base_d  = count;
`ifdef INTERVAL_TICK_ONESHOT_EN
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= 8'd0;
      period_q <= 8'd0;
      ticks_q  <= 8'd0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      period_q <= period_d;
      ticks_q  <= ticks_d;
      tick_q   <= tick_d;
    end
  end

  // Pure state decodes; no input reaches these combinationally.
  assign cfg_rdy = (state_q == S_IDLE);
  assign busy    = (state_q == S_RUN);
  assign tick    = tick_q;
  assign ticks   = ticks_q;

endmodule

// File: tb/tb_interval_tick_8b.sv
module tb_interval_tick_8b;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       cfg_val;
  logic [7:0] cfg_period;
  logic       cfg_rdy;
  logic       stop;
  logic       busy;
  logic       tick;
  logic [7:0] ticks;

  interval_tick_8b dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .cfg_val    (cfg_val),
    .cfg_period (cfg_period),
    .cfg_rdy    (cfg_rdy),
    .stop       (stop),
    .busy       (busy),
    .tick       (tick),
    .ticks      (ticks)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Upstream counter value sampled by the next edge, and the index of that edge.
  logic [7:0] count_r = 8'd0;
  int         edge_n = 0;

  // Reference model: schedule ticks by absolute edge index.
  logic       m_run = 1'b0;
  logic       m_tick = 1'b0;
  logic [7:0] m_ticks = 8'd0;
  int         m_period = 0;
  int         m_next = 0;

  typedef struct {
    logic       r;
    logic       cv;
    logic [7:0] cp;
    logic       st;
    logic       e_tick;
    logic [7:0] e_ticks;
    logic       e_busy;
  } vec_t;

  vec_t tbl[20];

  task automatic cmp(input string nm, input logic et, input logic [7:0] ets, input logic eb);
    vectors++;
    if (tick !== et || ticks !== ets || busy !== eb || cfg_rdy !== ~eb) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got tick=%0b ticks=%0d busy=%0b cfg_rdy=%0b, want tick=%0b ticks=%0d busy=%0b cfg_rdy=%0b",
               nm, edge_n, tick, ticks, busy, cfg_rdy, et, ets, eb, ~eb);
    end
  endtask

  task automatic step(input logic r, input logic cv, input logic [7:0] cp, input logic st);
    rst = r; cfg_val = cv; cfg_period = cp; stop = st; count = count_r;
    if (r) begin
      m_run = 1'b0; m_tick = 1'b0; m_ticks = 8'd0;
    end else if (!m_run) begin
      m_tick = 1'b0;
      if (cv && cp != 8'd0) begin
        m_run = 1'b1; m_period = int'(cp); m_next = edge_n + int'(cp); m_ticks = 8'd0;
      end
    end else if (st) begin
      m_run = 1'b0; m_tick = 1'b0;
    end else if (edge_n == m_next) begin
      m_tick = 1'b1; m_ticks = m_ticks + 8'd1; m_next = edge_n + m_period;
`ifdef INTERVAL_TICK_ONESHOT_EN
      m_run = 1'b0;
`endif
    end else begin
      m_tick = 1'b0;
    end
    @(posedge clk); #1;
    cmp("model", m_tick, m_ticks, m_run);
    count_r = count_r + 8'd1;
    edge_n++;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // Leave RUN if needed, then idle until the next edge samples count == v.
  task automatic align(input logic [7:0] v);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 300 && count_r != v; i++) idle_step();
  endtask

  initial begin
    rst = 1'b1; cfg_val = 1'b0; cfg_period = 8'd0; stop = 1'b0; count = 8'd0;

    // Periodic p=4 accepted with count=10; row i is sampled at count 10+i.
    tbl[0]  = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0};

    // Reset for two cycles.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    cmp("reset", 1'b0, 8'd0, 1'b0);

`ifndef INTERVAL_TICK_ONESHOT_EN
    // Basic period, busy reject, stop collision, zero period.
    align(8'd10);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].cv, tbl[i].cp, tbl[i].st);
      cmp($sformatf("table[%0d]", i), tbl[i].e_tick, tbl[i].e_ticks, tbl[i].e_busy);
    end

    // Wrap-around: p=8 at count 252, ticks raised at counts 4 and 12.
    align(8'd252);
    step(1'b0, 1'b1, 8'd8, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      idle_step();
      cmp("wrap", (k == 8 || k == 16), (k >= 16) ? 8'd2 : (k >= 8) ? 8'd1 : 8'd0, 1'b1);
    end

    // Period 1: tick every cycle, tally follows.
    align(8'd100);
    step(1'b0, 1'b1, 8'd1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      idle_step();
      cmp("period1", 1'b1, 8'(k), 1'b1);
    end
`else
    // One-shot: p=3 gives exactly one tick, returning to IDLE on that edge.
    align(8'd40);
    step(1'b0, 1'b1, 8'd3, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      idle_step();
      cmp("oneshot", (k == 3), (k >= 3) ? 8'd1 : 8'd0, (k < 3));
    end
`endif

    // Reset two cycles before the expected tick.
    align(8'd60);
    step(1'b0, 1'b1, 8'd5, 1'b0);
    idle_step();
    idle_step();
    step(1'b1, 1'b0, 8'd0, 1'b0);
    cmp("rst_midrun", 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle_step();
      cmp("after_rst", 1'b0, 8'd0, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      logic       r, cv, st;
      logic [7:0] cp;
      r  = ($urandom_range(63) == 0);
      cv = ($urandom_range(3) == 0);
      st = ($urandom_range(31) == 0);
      case ($urandom_range(7))
        0:       cp = 8'd0;
        1, 2:    cp = 8'($urandom_range(255));
        default: cp = 8'($urandom_range(12, 1));
      endcase
      step(r, cv, cp, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
